// File: rtl/accumulator_core.sv
// Running-sum register with synchronous clear, one carry bit above the operand width.
// Build option: define ACCUMULATOR_CORE_SATURATE_EN to clamp at all-ones instead of wrapping.
module accumulator_core #(
    parameter int BITWIDTH = 32
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iClr,
    input  logic [BITWIDTH-1:0] iData,
    output logic [BITWIDTH:0]   oData
);

    logic [BITWIDTH:0] acc_q;
    logic [BITWIDTH:0] acc_d;

`ifdef ACCUMULATOR_CORE_SATURATE_EN
    // One extra bit catches the carry out of the accumulator MSB.
    logic [BITWIDTH+1:0] sum;

    always_comb begin
        sum = {1'b0, acc_q} + {2'b00, iData};
    end

    always_comb begin
        acc_d = acc_q;
        if (iClr) begin
            acc_d = '0;
        end else if (iEn) begin
            acc_d = sum[BITWIDTH+1] ? '1 : sum[BITWIDTH:0];
        end
    end
`else
    logic [BITWIDTH:0] sum;

    // Carry out of the MSB is dropped, giving modulo 2^(BITWIDTH+1) wrap.
    always_comb begin
        sum = acc_q + {1'b0, iData};
    end

    always_comb begin
        acc_d = acc_q;
        if (iClr) begin
            acc_d = '0;
        end else if (iEn) begin
            acc_d = sum;
        end
    end
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign oData = acc_q;

endmodule

// File: tb/tb_accumulator_core.sv
// Self-checking bench for accumulator_core: 32-bit instance for the main stream, 4-bit instance for wrap/saturate.
module tb_accumulator_core;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic [31:0] data;
  logic [32:0] odata;

  logic        en4;
  logic        clr4;
  logic [3:0]  data4;
  logic [4:0]  odata4;

  int checks;
  int errors;

  logic [32:0] exp_q[$];
  logic [32:0] model_acc;

  typedef struct {
    logic        en;
    logic        clr;
    logic [31:0] data;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs[$];

  accumulator_core #(.BITWIDTH(32)) u_dut (
    .iClk (clk),
    .iRst (rst),
    .iEn  (en),
    .iClr (clr),
    .iData(data),
    .oData(odata)
  );

  accumulator_core #(.BITWIDTH(4)) u_small (
    .iClk (clk),
    .iRst (rst),
    .iEn  (en4),
    .iClr (clr4),
    .iData(data4),
    .oData(odata4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model of one edge for the 32-bit instance
  function automatic logic [32:0] model_next(logic [32:0] acc, logic e, logic c, logic [31:0] d);
    logic [33:0] s;
    s = {1'b0, acc} + {2'b00, d};
    if (c) return '0;
    if (!e) return acc;
`ifdef ACCUMULATOR_CORE_SATURATE_EN
    if (s[33]) return '1;
`endif
    return s[32:0];
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic e, input logic c, input logic [31:0] d, input logic [32:0] x);
    vec_t v;
    v.en = e;
    v.clr = c;
    v.data = d;
    v.exp = x;
    vecs.push_back(v);
  endtask

  // driver: apply inputs and push the model's prediction
  task automatic drive_m(input logic e, input logic c, input logic [31:0] d);
    en = e;
    clr = c;
    data = d;
    model_acc = model_next(model_acc, e, c, d);
    exp_q.push_back(model_acc);
  endtask

  // scoreboard: one edge, then pop and compare
  task automatic step(input string name);
    logic [32:0] x;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0d", name, odata);
    end else begin
      x = exp_q.pop_front();
      check(name, odata, x);
    end
  endtask

  task automatic step_small(input string name, input logic [4:0] exp);
    @(posedge clk);
    #1;
    check(name, {28'd0, odata4}, {28'd0, exp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_acc = '0;
    rst = 1'b1;
    en = 1'b1;
    clr = 1'b0;
    data = 32'd10;
    en4 = 1'b0;
    clr4 = 1'b0;
    data4 = 4'd0;

    // reset hold: enable active but output pinned at 0
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", odata, 33'd0);
    end
    check("reset_small", {28'd0, odata4}, 33'd0);
    rst = 1'b0;

    // vector table
    for (int i = 1; i <= 40; i++) add_vec(1'b1, 1'b0, 32'd10, 33'(10 * i));
    for (int i = 0; i < 40; i++) add_vec(1'b1, 1'b1, 32'd10, 33'd0);
    add_vec(1'b1, 1'b0, 32'd10, 33'd10);
    for (int i = 0; i < 5; i++) add_vec(1'b0, 1'b0, 32'd10, 33'd10);
    for (int i = 1; i <= 3; i++) add_vec(1'b1, 1'b0, 32'd10, 33'(10 + 10 * i));
    add_vec(1'b1, 1'b0, 32'd0, 33'd40);
    add_vec(1'b0, 1'b0, 32'd77, 33'd40);
    add_vec(1'b1, 1'b1, 32'd99, 33'd0);
    add_vec(1'b1, 1'b0, 32'hFFFF_FFFF, 33'h0_FFFF_FFFF);
    add_vec(1'b1, 1'b0, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
    add_vec(1'b1, 1'b1, 32'd5, 33'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en;
      clr = vecs[i].clr;
      data = vecs[i].data;
      exp_q.push_back(vecs[i].exp);
      model_acc = vecs[i].exp;
      step($sformatf("vec[%0d]", i));
    end
    if (vecs[40 - 1].exp != 33'd400) $display("note: table row 39 is not 400");

    // reset mid-run: build to 200, then pulse reset between edges
    for (int i = 0; i < 20; i++) begin
      drive_m(1'b1, 1'b0, 32'd10);
      step("run_to_200");
    end
    check("at_200", odata, 33'd200);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", odata, 33'd0);
    #1;
    rst = 1'b0;
    model_acc = '0;
    drive_m(1'b1, 1'b0, 32'd10);
    step("after_rst");

    // 4-bit wrap / saturate
    drive_m(1'b0, 1'b0, 32'd0);
    en4 = 1'b1;
    data4 = 4'd15;
    step_small("small_15", 5'd15);
    step_small("small_30", 5'd30);
    data4 = 4'd5;
`ifdef ACCUMULATOR_CORE_SATURATE_EN
    step_small("small_sat", 5'd31);
    step_small("small_sat_hold", 5'd31);
    en4 = 1'b0;
    step_small("small_idle", 5'd31);
`else
    step_small("small_wrap", 5'd3);
    step_small("small_wrap_next", 5'd8);
    en4 = 1'b0;
    step_small("small_idle", 5'd8);
`endif
    en4 = 1'b1;
    clr4 = 1'b1;
    step_small("small_clr", 5'd0);
    clr4 = 1'b0;
    step_small("small_resume", 5'd5);
    en4 = 1'b0;
    // drain the scoreboard entries queued while the small instance ran
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    exp_q.delete();

    // random stream with large operands to reach the top of the range
    for (int i = 0; i < 60; i++) begin
      drive_m($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
      step($sformatf("rand[%0d]", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
